// File: rtl/seq_divider_fx.sv
// seq_divider_fx: multi-cycle restoring divider producing a fixed-point
// quotient (a * 2^FRAC) / b with FRAC fraction bits.
// Supports unsigned and two's-complement operands.
// Reports divide-by-zero, and saturates the quotient when it does not fit.
// Uses a start/busy/done handshake. Results hold until the next accepted start.
module seq_divider_fx #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ovf,
  output logic             dvz
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [N:0] ONE  = (N+1)'(1);
  localparam logic [N:0] ULIM = (ONE << WIDTH) - ONE;
  localparam logic [N:0] PLIM = (ONE << (WIDTH - 1)) - ONE;
  localparam logic [N:0] NLIM = ONE << (WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, DONE} state_t;

  state_t           state, next_state;
  logic             sm_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [N-1:0]     q_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt;

  logic             accept, last_iter;
  logic             a_neg, b_neg, neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   acc_sh;
  logic [N-1:0]     q_sh;
  logic             ge;
  logic [WIDTH-1:0] trial;
  logic [N:0]       q_ext;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             ovf_fix;

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_iter = (cnt == CW'(N - 1));

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode plus the busy/done flags, which depend only on the state
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: begin
        busy       = 1'b1;
        next_state = (b_mag == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) next_state = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = start ? LOAD : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand magnitudes and signs taken from the latched operands
  always_comb begin
    a_neg = sm_r & a_r[WIDTH-1];
    b_neg = sm_r & b_r[WIDTH-1];
    neg   = a_neg ^ b_neg;
    a_mag = a_neg ? -a_r : a_r;
    b_mag = b_neg ? -b_r : b_r;
  end

  // One restoring step: shift {A,Q} left, then subtract |b| if it fits.
  // The restored partial remainder is always below |b|, so it fits in WIDTH bits.
  // That also lets the low WIDTH bits of the subtraction stand in for the full difference.
  always_comb begin
    acc_sh = {acc_r, q_r[N-1]};
    q_sh   = {q_r[N-2:0], 1'b0};
    ge     = (acc_sh >= {1'b0, b_mag});
    trial  = acc_sh[WIDTH-1:0] - b_mag;
  end

  // Sign restoration and saturation of the raw magnitude quotient
  always_comb begin
    q_ext   = {1'b0, q_r};
    ovf_fix = 1'b0;
    q_fix   = q_r[WIDTH-1:0];
    if (!sm_r) begin
      if (q_ext > ULIM) begin
        ovf_fix = 1'b1;
        q_fix   = '1;
      end
    end else if (!neg) begin
      if (q_ext > PLIM) begin
        ovf_fix = 1'b1;
        q_fix   = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      if (q_ext > NLIM) begin
        ovf_fix = 1'b1;
        q_fix   = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        q_fix = -q_r[WIDTH-1:0];
      end
    end
    r_fix = a_neg ? -acc_r : acc_r;
  end

  // Operand capture, iteration registers and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sm_r      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      q_r       <= '0;
      acc_r     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dvz       <= 1'b0;
    end else begin
      if (accept) begin
        sm_r <= signed_mode;
        a_r  <= a_in;
        b_r  <= b_in;
        ovf  <= 1'b0;
        dvz  <= 1'b0;
      end
      case (state)
        LOAD: begin
          if (b_mag == '0) begin
            dvz       <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else begin
            q_r   <= N'(a_mag) << FRAC;
            acc_r <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          if (ge) begin
            acc_r <= trial;
            q_r   <= {q_sh[N-1:1], 1'b1};
          end else begin
            acc_r <= acc_sh[WIDTH-1:0];
            q_r   <= q_sh;
          end
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          ovf       <= ovf_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_fx.sv
// tb_seq_divider_fx: scoreboard bench for seq_divider_fx (WIDTH=10, FRAC=4).
// Stimulus pushes reference results into a queue.
// A monitor pops and compares entries whenever done is seen.
module tb_seq_divider_fx;

  localparam int W = 10;
  localparam int F = 4;
  localparam int N = W + F;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a_in, b_in;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
  logic         ovf, dvz;

  int cyc    = 0;
  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    logic         dvz;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  seq_divider_fx #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .ovf(ovf), .dvz(dvz)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run always ends
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: plain integer division on magnitudes, then sign and saturation
  function automatic exp_t model(input logic sm, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int now);
    exp_t   e;
    longint ua, ub, num, qq, rr, lim;
    logic   an, bn;
    an    = sm & a[W-1];
    bn    = sm & b[W-1];
    ua    = an ? (longint'(1) << W) - longint'(a) : longint'(a);
    ub    = bn ? (longint'(1) << W) - longint'(b) : longint'(b);
    e.ovf = 1'b0;
    e.dvz = 1'b0;
    if (ub == 0) begin
      e.dvz = 1'b1;
      e.q   = '0;
      e.r   = '0;
      e.due = now + 2;
      return e;
    end
    num   = ua << F;
    qq    = num / ub;
    rr    = num % ub;
    e.due = now + N + 3;
    if (!sm) begin
      lim = (longint'(1) << W) - 1;
      if (qq > lim) begin e.ovf = 1'b1; qq = lim; end
    end else if (an == bn) begin
      lim = (longint'(1) << (W - 1)) - 1;
      if (qq > lim) begin e.ovf = 1'b1; qq = lim; end
    end else begin
      lim = longint'(1) << (W - 1);
      if (qq > lim) begin e.ovf = 1'b1; qq = lim; end
      qq = -qq;
    end
    e.q = W'(qq);
    e.r = W'(an ? -rr : rr);
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check_output("unexpected_done", 32'(done), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check_output("quotient",   32'(quotient),  32'(mon_e.q));
        check_output("remainder",  32'(remainder), 32'(mon_e.r));
        check_output("ovf",        32'(ovf),       32'(mon_e.ovf));
        check_output("dvz",        32'(dvz),       32'(mon_e.dvz));
        check_output("done_cycle", 32'(cyc),       32'(mon_e.due));
        check_output("busy_at_done", 32'(busy),    32'(0));
      end
    end
  end

  // Issue one operation at the current negedge and walk through its busy cycles.
  // Operand inputs are scrambled after acceptance.
  // With hold=1, start also stays high while busy.
  task automatic apply_stimulus(input logic sm, input logic [W-1:0] a,
                                input logic [W-1:0] b, input bit hold);
    int nb;
    signed_mode = sm;
    a_in        = a;
    b_in        = b;
    start       = 1'b1;
    sb.push_back(model(sm, a, b, cyc));
    nb = (b == '0) ? 1 : N + 2;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      check_output("busy", 32'(busy), 32'(1));
      a_in        = W'($urandom);
      b_in        = W'($urandom);
      signed_mode = 1'($urandom);
      start       = hold;
    end
  endtask

  // Wait (bounded) until the negedge at which done is high
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    check_output("done_seen", 32'(ok), 32'(1));
  endtask

  task automatic run_one(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    apply_stimulus(sm, a, b, 1'b0);
    wait_done();
    start = 1'b0;
    @(negedge clk);
  endtask

  // Main stimulus sequence
  initial begin
    logic         sm;
    logic [W-1:0] a, b;
    bit           hold, b2b;
    int           sel;

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check_output("rst_busy",      32'(busy),      32'(0));
    check_output("rst_done",      32'(done),      32'(0));
    check_output("rst_quotient",  32'(quotient),  32'(0));
    check_output("rst_remainder", 32'(remainder), 32'(0));
    check_output("rst_ovf",       32'(ovf),       32'(0));
    check_output("rst_dvz",       32'(dvz),       32'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed cases");
    run_one(1'b0, W'(100),  W'(7));
    run_one(1'b0, W'(1000), W'(3));
    run_one(1'b0, W'(55),   W'(0));
    run_one(1'b1, W'(-100), W'(7));
    run_one(1'b1, W'(-32),  W'(1));
    run_one(1'b1, W'(300),  W'(1));
    run_one(1'b1, W'(-33),  W'(1));
    run_one(1'b1, W'(31),   W'(1));
    run_one(1'b1, W'(-512), W'(-1));
    run_one(1'b1, W'(-512), W'(0));
    run_one(1'b1, W'(100),  W'(-7));
    run_one(1'b1, W'(-100), W'(-7));
    run_one(1'b0, W'(1023), W'(1023));
    run_one(1'b0, W'(0),    W'(5));
    run_one(1'b0, W'(1023), W'(1));

    $display("[TB] start held while busy, then back-to-back from DONE");
    apply_stimulus(1'b0, W'(200), W'(9), 1'b1);
    wait_done();
    apply_stimulus(1'b1, W'(-77), W'(5), 1'b0);
    wait_done();
    start = 1'b0;
    @(negedge clk);

    $display("[TB] reset during CALC");
    signed_mode = 1'b0; a_in = W'(1000); b_in = W'(7); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("abort_busy",      32'(busy),      32'(0));
    check_output("abort_done",      32'(done),      32'(0));
    check_output("abort_quotient",  32'(quotient),  32'(0));
    check_output("abort_remainder", 32'(remainder), 32'(0));
    check_output("abort_ovf",       32'(ovf),       32'(0));
    check_output("abort_dvz",       32'(dvz),       32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 6) @(negedge clk);
    check_output("abort_idle_busy", 32'(busy), 32'(0));

    $display("[TB] random sweep");
    b2b = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
      sm  = 1'($urandom);
      a   = W'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel <= 3) b = W'($urandom_range(1, 7));
      else               b = W'($urandom);
      if (sel == 1) b = -b;
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 1) ? {1'b1, {(W-1){1'b0}}} : '1;
      hold = ($urandom_range(0, 7) == 0);
      apply_stimulus(sm, a, b, hold);
      wait_done();
      b2b = hold || ($urandom_range(0, 3) == 0);
      if (!b2b) begin
        start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;

    repeat (5) @(negedge clk);
    check_output("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
